and_gate: RTL and testbench

- Parameterised bitwise AND with an optional register pipeline and summary flags on the result.
- Default configuration (WIDTH=1, LATENCY=0) is a plain 2-input AND gate: y = a & b, combinational.
- Used as a leaf primitive in datapath masking and enable-qualification logic.
- Wider or pipelined instances share the same interface.

---
 rtl/and_gate_if.sv | 37 +++
 rtl/and_gate.sv | 91 +++++++++
 tb/tb_and_gate.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/and_gate_if.sv
`default_nettype none
// ============================================================================
//  Module   : and_gate_if
//  Purpose  : Groups the operand/result signals of and_gate into one bundle.
//  Ports    : none (signals carried inside the interface)
//             in_valid, a, b                  - driven by the producer
//             out_valid, y, y_all, y_any,
//             y_count                         - driven by and_gate
//  Modports : master - producer/consumer side (drives operands)
//             slave  - and_gate side (drives results)
//  Revision : 1.0 - initial release
// ============================================================================
interface and_gate_if #(
  parameter int WIDTH = 1
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] y;
  logic             y_all;
  logic             y_any;
  logic [CW-1:0]    y_count;

  modport master (
    output in_valid, a, b,
    input  out_valid, y, y_all, y_any, y_count
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, y, y_all, y_any, y_count
  );
endinterface
`default_nettype wire

// File: rtl/and_gate.sv
`default_nettype none
// ============================================================================
//  Module   : and_gate
//  Purpose  : Parameterised bitwise AND with an optional LATENCY-deep register
//             pipeline and summary flags (all/any/popcount) on the result.
//  Ports    : clk  - rising-edge clock (unused when LATENCY = 0)
//             rst  - synchronous active-high reset (unused when LATENCY = 0)
//             bus  - and_gate_if.slave:
//                      in_valid, a, b            (inputs)
//                      out_valid, y, y_all,
//                      y_any, y_count            (outputs)
//  Params   : WIDTH   1..64  operand/result width
//             LATENCY 0..4   register stages between inputs and outputs
//  Revision : 1.0 - initial release
// ============================================================================
module and_gate #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 0
) (
  input  wire        clk,
  input  wire        rst,
  and_gate_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             w_out_valid;
  logic [WIDTH-1:0] w_y;
  logic [CW-1:0]    w_y_count;

  generate
    if (LATENCY == 0) begin : g_comb
      // Pure combinational path: clk/rst are intentionally left unconnected
      // in function, folded here so they are not reported as dangling.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};

      assign w_out_valid = bus.in_valid;
      assign w_y         = bus.a & bus.b;
    end else begin : g_pipe
      logic [LATENCY-1:0] valid_q;
      logic [LATENCY-1:0] valid_d;
      logic [WIDTH-1:0]   data_q [LATENCY];
      logic [WIDTH-1:0]   data_d [LATENCY];

      // Valid always shifts; data of a stage only reloads when the valid
      // arriving at it is set, so the output holds the last real result
      // across bubbles.
      always_comb begin
        valid_d[0] = bus.in_valid;
        data_d[0]  = bus.in_valid ? (bus.a & bus.b) : data_q[0];
        for (int i = 1; i < LATENCY; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= '0;
          for (int i = 0; i < LATENCY; i++) begin
            data_q[i] <= '0;
          end
        end else begin
          valid_q <= valid_d;
          for (int i = 0; i < LATENCY; i++) begin
            data_q[i] <= data_d[i];
          end
        end
      end

      assign w_out_valid = valid_q[LATENCY-1];
      assign w_y         = data_q[LATENCY-1];
    end
  endgenerate

  // Summary flags come from the presented (delayed) result, never from a/b.
  always_comb begin
    w_y_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_y_count = w_y_count + CW'(w_y[i]);
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.y         = w_y;
  assign bus.y_all     = &w_y;
  assign bus.y_any     = |w_y;
  assign bus.y_count   = w_y_count;

endmodule
`default_nettype wire

// File: tb/tb_and_gate.sv
`default_nettype none
// ============================================================================
//  Module   : tb_and_gate
//  Purpose  : Directed self-checking bench for and_gate covering the
//             combinational, pipelined, bubble, mid-stream reset and
//             random-vector configurations.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_and_gate;
  logic clk;
  logic rst_w1, rst_w8c, rst_w8p, rst_w4, rst_w16;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  and_gate_if #(.WIDTH(1))  if_w1  ();
  and_gate_if #(.WIDTH(8))  if_w8c ();
  and_gate_if #(.WIDTH(8))  if_w8p ();
  and_gate_if #(.WIDTH(4))  if_w4  ();
  and_gate_if #(.WIDTH(16)) if_w16 ();

  and_gate #(.WIDTH(1),  .LATENCY(0)) u_w1  (.clk(clk), .rst(rst_w1),  .bus(if_w1));
  and_gate #(.WIDTH(8),  .LATENCY(0)) u_w8c (.clk(clk), .rst(rst_w8c), .bus(if_w8c));
  and_gate #(.WIDTH(8),  .LATENCY(2)) u_w8p (.clk(clk), .rst(rst_w8p), .bus(if_w8p));
  and_gate #(.WIDTH(4),  .LATENCY(3)) u_w4  (.clk(clk), .rst(rst_w4),  .bus(if_w4));
  and_gate #(.WIDTH(16), .LATENCY(1)) u_w16 (.clk(clk), .rst(rst_w16), .bus(if_w16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w8p(input string tag, input logic v, input logic [7:0] y,
                         input logic all, input logic any, input logic [3:0] cnt);
    chk({tag, ".out_valid"}, 64'(if_w8p.out_valid), 64'(v));
    chk({tag, ".y"},         64'(if_w8p.y),         64'(y));
    chk({tag, ".y_all"},     64'(if_w8p.y_all),     64'(all));
    chk({tag, ".y_any"},     64'(if_w8p.y_any),     64'(any));
    chk({tag, ".y_count"},   64'(if_w8p.y_count),   64'(cnt));
  endtask

  task automatic chk_w4(input string tag, input logic v, input logic [3:0] y,
                        input logic [2:0] cnt);
    chk({tag, ".out_valid"}, 64'(if_w4.out_valid), 64'(v));
    chk({tag, ".y"},         64'(if_w4.y),         64'(y));
    chk({tag, ".y_count"},   64'(if_w4.y_count),   64'(cnt));
  endtask

  initial begin
    logic [3:0]  tt_y;
    logic [15:0] ra, rb, exp_y;
    logic        riv, exp_v;

    checks = 0;
    errors = 0;
    rst_w1 = 1'b0; rst_w8c = 1'b0;
    rst_w8p = 1'b1; rst_w4 = 1'b1; rst_w16 = 1'b1;
    if_w1.in_valid  = 1'b1; if_w1.a  = '0; if_w1.b  = '0;
    if_w8c.in_valid = 1'b1; if_w8c.a = '0; if_w8c.b = '0;
    if_w8p.in_valid = 1'b0; if_w8p.a = '0; if_w8p.b = '0;
    if_w4.in_valid  = 1'b0; if_w4.a  = '0; if_w4.b  = '0;
    if_w16.in_valid = 1'b0; if_w16.a = '0; if_w16.b = '0;

    // ---------------- WIDTH=1, LATENCY=0: truth table ----------------
    tt_y = 4'b1000;  // index {a,b}: 00,01,10 -> 0, 11 -> 1
    for (int i = 0; i < 4; i++) begin
      if_w1.a = 1'(i >> 1);
      if_w1.b = 1'(i);
      #1;
      chk($sformatf("w1.y[%0d]", i),       64'(if_w1.y),       64'(tt_y[i]));
      chk($sformatf("w1.y_all[%0d]", i),   64'(if_w1.y_all),   64'(tt_y[i]));
      chk($sformatf("w1.y_any[%0d]", i),   64'(if_w1.y_any),   64'(tt_y[i]));
      chk($sformatf("w1.y_count[%0d]", i), 64'(if_w1.y_count), 64'(tt_y[i]));
      chk($sformatf("w1.out_valid[%0d]", i), 64'(if_w1.out_valid), 64'd1);
      #99;
    end
    if_w1.in_valid = 1'b0;
    #1;
    chk("w1.out_valid_low", 64'(if_w1.out_valid), 64'd0);
    chk("w1.y_no_valid",    64'(if_w1.y),         64'd1);

    // ---------------- WIDTH=8, LATENCY=0 ----------------
    if_w8c.a = 8'hF0; if_w8c.b = 8'h3C;
    #1;
    chk("w8c.y_30",       64'(if_w8c.y),       64'h30);
    chk("w8c.y_any_30",   64'(if_w8c.y_any),   64'd1);
    chk("w8c.y_all_30",   64'(if_w8c.y_all),   64'd0);
    chk("w8c.y_count_30", 64'(if_w8c.y_count), 64'd2);
    if_w8c.a = 8'hFF; if_w8c.b = 8'hFF;
    #1;
    chk("w8c.y_ff",       64'(if_w8c.y),       64'hFF);
    chk("w8c.y_all_ff",   64'(if_w8c.y_all),   64'd1);
    chk("w8c.y_count_ff", 64'(if_w8c.y_count), 64'd8);

    // ---------------- Reset state of the pipelined instances ----------------
    tick();
    tick();
    chk_w8p("w8p.reset", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    chk_w4("w4.reset", 1'b0, 4'h0, 3'd0);
    chk("w16.reset.out_valid", 64'(if_w16.out_valid), 64'd0);
    chk("w16.reset.y",         64'(if_w16.y),         64'd0);

    // ---------------- WIDTH=8, LATENCY=2: back-to-back ----------------
    rst_w8p = 1'b0;
    if_w8p.in_valid = 1'b1; if_w8p.a = 8'hAA; if_w8p.b = 8'hFF;
    tick();
    chk_w8p("w8p.fill", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    if_w8p.a = 8'h0F; if_w8p.b = 8'h05;
    tick();
    chk_w8p("w8p.r0", 1'b1, 8'hAA, 1'b0, 1'b1, 4'd4);
    if_w8p.a = 8'h00; if_w8p.b = 8'hFF;
    tick();
    chk_w8p("w8p.r1", 1'b1, 8'h05, 1'b0, 1'b1, 4'd2);
    if_w8p.in_valid = 1'b0;
    tick();
    chk_w8p("w8p.r2", 1'b1, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    chk_w8p("w8p.drain", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);

    // ---------------- WIDTH=8, LATENCY=2: bubble holds data ----------------
    if_w8p.in_valid = 1'b1; if_w8p.a = 8'h81; if_w8p.b = 8'hFF;
    tick();
    if_w8p.in_valid = 1'b0; if_w8p.a = 8'hFF; if_w8p.b = 8'hFF;
    tick();
    chk_w8p("w8p.bubble_v", 1'b1, 8'h81, 1'b0, 1'b1, 4'd2);
    tick();
    chk_w8p("w8p.bubble_hold", 1'b0, 8'h81, 1'b0, 1'b1, 4'd2);
    tick();
    chk_w8p("w8p.bubble_hold2", 1'b0, 8'h81, 1'b0, 1'b1, 4'd2);

    // ---------------- WIDTH=4, LATENCY=3: reset mid-stream ----------------
    rst_w4 = 1'b0;
    if_w4.in_valid = 1'b1; if_w4.a = 4'hF; if_w4.b = 4'hF;
    tick();
    if_w4.a = 4'hA; if_w4.b = 4'h6;
    tick();
    // third input presented together with reset: reset must win
    if_w4.a = 4'h7; if_w4.b = 4'h3;
    rst_w4 = 1'b1;
    tick();
    chk_w4("w4.rst_slot0", 1'b0, 4'h0, 3'd0);
    rst_w4 = 1'b0;
    if_w4.a = 4'hC; if_w4.b = 4'hF;
    tick();
    chk_w4("w4.rst_slot1", 1'b0, 4'h0, 3'd0);
    if_w4.in_valid = 1'b0; if_w4.a = 4'hF; if_w4.b = 4'hF;
    tick();
    chk_w4("w4.rst_slot2", 1'b0, 4'h0, 3'd0);
    tick();
    chk_w4("w4.after_rst", 1'b1, 4'hC, 3'd2);
    tick();
    chk_w4("w4.after_rst_hold", 1'b0, 4'hC, 3'd2);

    // ---------------- WIDTH=16, LATENCY=1: random vectors ----------------
    rst_w16 = 1'b0;
    exp_y = 16'h0000;
    exp_v = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      riv = ($urandom_range(0, 3) != 0);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        ra = 16'hFFFF;
        rb = 16'hFFFF;
      end
      if_w16.in_valid = riv; if_w16.a = ra; if_w16.b = rb;
      tick();
      exp_v = riv;
      if (riv) exp_y = ra & rb;
      chk("w16.out_valid", 64'(if_w16.out_valid), 64'(exp_v));
      chk("w16.y",         64'(if_w16.y),         64'(exp_y));
      chk("w16.y_count",   64'(if_w16.y_count),   64'($countones(exp_y)));
      chk("w16.y_all",     64'(if_w16.y_all),     64'(exp_y == 16'hFFFF));
      chk("w16.y_any",     64'(if_w16.y_any),     64'(exp_y != 16'h0000));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
